uvmt_cv32e40x_pma_obi_tracker: RTL and testbench

//  Bus-side tracker for one OBI port (instr or data) of the core.
//  - Captures each granted address phase together with the PMA verdict for that address.
//  - Queues it until the matching response phase.
//  - At response time, reports the address, PMA-derived memtype expectations and protocol errors.
//  - Sits beside the PMA model: that model judges an address; this block follows the transaction to completion.
//

---
 rtl/uvmt_cv32e40x_pma_obi_tracker_if.sv | 19 +
 rtl/uvmt_cv32e40x_pma_obi_tracker.sv | 90 +++++++++
 tb/tb_uvmt_cv32e40x_pma_obi_tracker.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/uvmt_cv32e40x_pma_obi_tracker_if.sv
// uvmt_cv32e40x_pma_obi_tracker_if: OBI address/response bus plus the PMA verdict for the current address
interface uvmt_cv32e40x_pma_obi_tracker_if;
  typedef struct packed {
    logic allow;
    logic bufferable;
    logic cacheable;
  } pma_status_t;
  logic        obi_req;
  logic        obi_gnt;
  logic [31:0] obi_addr;
  logic [1:0]  obi_memtype;
  logic        obi_we;
  logic        obi_rvalid;
  logic        obi_err;
  pma_status_t pma_status;
  modport master (output obi_req, obi_addr, obi_memtype, obi_we, input obi_gnt, obi_rvalid, obi_err, pma_status);
  modport slave (input obi_req, obi_addr, obi_memtype, obi_we, output obi_gnt, obi_rvalid, obi_err, pma_status);
  modport monitor (input obi_req, obi_gnt, obi_addr, obi_memtype, obi_we, obi_rvalid, obi_err, pma_status);
endinterface

// File: rtl/uvmt_cv32e40x_pma_obi_tracker.sv
// uvmt_cv32e40x_pma_obi_tracker: follows granted OBI transactions to their response and reports PMA/protocol issues
module uvmt_cv32e40x_pma_obi_tracker #(
  parameter bit IS_INSTR_SIDE   = 1'b0,
  parameter int MAX_OUTSTANDING = 2,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uvmt_cv32e40x_pma_obi_tracker_if.monitor bus,
  output logic [CW-1:0]           outstanding,
  output logic                    rsp_valid,
  output logic [31:0]             rsp_addr,
  output logic                    rsp_we,
  output logic                    rsp_err,
  output logic                    rsp_memtype_mismatch,
  output logic                    rsp_blocked,
  output logic                    overflow_err,
  output logic                    underflow_err,
  output logic                    addr_stable_err
);
  logic [31:0]   addr_q [MAX_OUTSTANDING];
  logic          we_q   [MAX_OUTSTANDING];
  logic          mm_q   [MAX_OUTSTANDING];
  logic          blk_q  [MAX_OUTSTANDING];
  logic [PW-1:0] wptr, rptr;
  logic          push, pop, accept, full, empty, mm_new, waiting, prev_we;
  logic [31:0]   prev_addr;
  logic [1:0]    prev_memtype;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction
  assign push   = bus.obi_req && bus.obi_gnt;
  assign empty  = outstanding == '0;
  assign full   = outstanding == CW'(MAX_OUTSTANDING);
  assign pop    = bus.obi_rvalid && !empty;
  assign accept = push && (!full || pop);
  assign mm_new = (bus.obi_memtype[0] != (bus.pma_status.bufferable && !IS_INSTR_SIDE)) ||
                  (bus.obi_memtype[1] != bus.pma_status.cacheable);
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[wptr] <= bus.obi_addr;
      we_q[wptr]   <= bus.obi_we;
      mm_q[wptr]   <= mm_new;
      blk_q[wptr]  <= !bus.pma_status.allow;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr                 <= '0;
      rptr                 <= '0;
      outstanding          <= '0;
      rsp_valid            <= 1'b0;
      rsp_addr             <= '0;
      rsp_we               <= 1'b0;
      rsp_err              <= 1'b0;
      rsp_memtype_mismatch <= 1'b0;
      rsp_blocked          <= 1'b0;
      overflow_err         <= 1'b0;
      underflow_err        <= 1'b0;
      addr_stable_err      <= 1'b0;
      waiting              <= 1'b0;
      prev_addr            <= '0;
      prev_we              <= 1'b0;
      prev_memtype         <= '0;
    end else begin
      if (accept) wptr <= nxt(wptr);
      if (pop) rptr <= nxt(rptr);
      outstanding <= outstanding + CW'(accept) - CW'(pop);
      rsp_valid   <= pop;
      if (pop) begin
        rsp_addr             <= addr_q[rptr];
        rsp_we               <= we_q[rptr];
        rsp_err              <= bus.obi_err;
        rsp_memtype_mismatch <= mm_q[rptr];
        rsp_blocked          <= blk_q[rptr];
      end
      if (push && full && !pop) overflow_err <= 1'b1;
      // a response on an empty FIFO is an underflow even if a grant arrives in the same cycle
      if (bus.obi_rvalid && empty) underflow_err <= 1'b1;
      waiting      <= bus.obi_req && !bus.obi_gnt;
      prev_addr    <= bus.obi_addr;
      prev_we      <= bus.obi_we;
      prev_memtype <= bus.obi_memtype;
      if (waiting && (!bus.obi_req || bus.obi_addr != prev_addr || bus.obi_we != prev_we ||
                      bus.obi_memtype != prev_memtype))
        addr_stable_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uvmt_cv32e40x_pma_obi_tracker.sv
// tb_uvmt_cv32e40x_pma_obi_tracker: directed checks of data- and instr-side trackers sharing one bus
module tb_uvmt_cv32e40x_pma_obi_tracker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   fails = 0;
  uvmt_cv32e40x_pma_obi_tracker_if bus ();
  logic [1:0]  d_out, i_out;
  logic [31:0] d_addr, i_addr;
  logic d_vld, d_we, d_err, d_mm, d_blk, d_ovf, d_unf, d_stb;
  logic i_vld, i_we, i_err, i_mm, i_blk, i_ovf, i_unf, i_stb;
  always #5 clk = ~clk;
  uvmt_cv32e40x_pma_obi_tracker #(.IS_INSTR_SIDE(1'b0), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .outstanding(d_out), .rsp_valid(d_vld), .rsp_addr(d_addr),
    .rsp_we(d_we), .rsp_err(d_err), .rsp_memtype_mismatch(d_mm), .rsp_blocked(d_blk),
    .overflow_err(d_ovf), .underflow_err(d_unf), .addr_stable_err(d_stb));
  uvmt_cv32e40x_pma_obi_tracker #(.IS_INSTR_SIDE(1'b1), .MAX_OUTSTANDING(2)) dut_i (
    .clk(clk), .rst_n(rst_n), .bus(bus), .outstanding(i_out), .rsp_valid(i_vld), .rsp_addr(i_addr),
    .rsp_we(i_we), .rsp_err(i_err), .rsp_memtype_mismatch(i_mm), .rsp_blocked(i_blk),
    .overflow_err(i_ovf), .underflow_err(i_unf), .addr_stable_err(i_stb));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic rq, input logic gn, input logic [31:0] a, input logic w,
                     input logic [1:0] mt, input logic rv, input logic er);
    bus.obi_req = rq; bus.obi_gnt = gn; bus.obi_addr = a; bus.obi_we = w;
    bus.obi_memtype = mt; bus.obi_rvalid = rv; bus.obi_err = er;
    @(posedge clk);
    #1;
  endtask
  task automatic pma(input logic al, input logic bf, input logic ca);
    bus.pma_status.allow = al; bus.pma_status.bufferable = bf; bus.pma_status.cacheable = ca;
  endtask
  task automatic idle();
    cyc(0, 0, 32'h0, 0, 2'b00, 0, 0);
  endtask
  task automatic flags(input string tag, input logic o, input logic u, input logic s);
    chk({tag, "_ovf"}, 32'(d_ovf), 32'(o));
    chk({tag, "_unf"}, 32'(d_unf), 32'(u));
    chk({tag, "_stb"}, 32'(d_stb), 32'(s));
  endtask
  initial begin
    pma(1, 0, 0);
    idle();
    idle();
    chk("rst_out", 32'(d_out), 0);
    chk("rst_vld", 32'(d_vld), 0);
    chk("rst_addr", d_addr, 0);
    flags("rst", 0, 0, 0);
    rst_n = 1'b1;
    // single transaction
    cyc(1, 1, 32'h1000, 0, 2'b00, 0, 0);
    chk("t1_out", 32'(d_out), 1);
    chk("t1_novld", 32'(d_vld), 0);
    idle();
    cyc(0, 0, 32'h0, 0, 2'b00, 1, 0);
    chk("t1_vld", 32'(d_vld), 1);
    chk("t1_addr", d_addr, 32'h1000);
    chk("t1_mm", 32'(d_mm), 0);
    chk("t1_blk", 32'(d_blk), 0);
    chk("t1_out0", 32'(d_out), 0);
    idle();
    chk("t1_pulse_end", 32'(d_vld), 0);
    chk("t1_hold", d_addr, 32'h1000);
    // back-to-back
    cyc(1, 1, 32'h100, 0, 2'b00, 0, 0);
    cyc(1, 1, 32'h104, 1, 2'b00, 0, 0);
    chk("b2b_out2", 32'(d_out), 2);
    cyc(0, 0, 32'h0, 0, 2'b00, 1, 0);
    chk("b2b_a", d_addr, 32'h100);
    chk("b2b_we_a", 32'(d_we), 0);
    chk("b2b_out1", 32'(d_out), 1);
    cyc(0, 0, 32'h0, 0, 2'b00, 1, 0);
    chk("b2b_vld_b", 32'(d_vld), 1);
    chk("b2b_b", d_addr, 32'h104);
    chk("b2b_we_b", 32'(d_we), 1);
    chk("b2b_out0", 32'(d_out), 0);
    // full, push+pop at full, then overflow
    cyc(1, 1, 32'h300, 0, 2'b00, 0, 0);
    cyc(1, 1, 32'h304, 0, 2'b00, 0, 0);
    cyc(1, 1, 32'h308, 0, 2'b00, 1, 0);
    chk("full_pp_out", 32'(d_out), 2);
    chk("full_pp_addr", d_addr, 32'h300);
    chk("full_pp_ovf", 32'(d_ovf), 0);
    cyc(1, 1, 32'h30C, 0, 2'b00, 0, 0);
    chk("ovf_set", 32'(d_ovf), 1);
    chk("ovf_out", 32'(d_out), 2);
    idle();
    chk("ovf_sticky", 32'(d_ovf), 1);
    cyc(0, 0, 32'h0, 0, 2'b00, 1, 0);
    chk("drain_a", d_addr, 32'h304);
    chk("drain_err0", 32'(d_err), 0);
    cyc(0, 0, 32'h0, 0, 2'b00, 1, 1);
    chk("drain_b", d_addr, 32'h308);
    chk("drain_err1", 32'(d_err), 1);
    chk("drain_out", 32'(d_out), 0);
    flags("drain", 1, 0, 0);
    // memtype / PMA expectations
    pma(1, 1, 0);
    cyc(1, 1, 32'h400, 0, 2'b01, 0, 0);
    pma(1, 0, 0);
    cyc(0, 0, 32'h0, 0, 2'b00, 1, 0);
    chk("mt_d_mm", 32'(d_mm), 0);
    chk("mt_i_mm", 32'(i_mm), 1);
    chk("mt_i_addr", i_addr, 32'h400);
    cyc(1, 1, 32'h410, 0, 2'b10, 0, 0);
    cyc(0, 0, 32'h0, 0, 2'b00, 1, 0);
    chk("mt_c_mm", 32'(d_mm), 1);
    pma(0, 0, 0);
    cyc(1, 1, 32'h500, 0, 2'b00, 0, 0);
    pma(1, 0, 0);
    cyc(0, 0, 32'h0, 0, 2'b00, 1, 0);
    chk("blk_d", 32'(d_blk), 1);
    chk("blk_mm", 32'(d_mm), 0);
    chk("blk_i", 32'(i_blk), 1);
    // legal wait then stability violation
    cyc(1, 0, 32'h600, 0, 2'b00, 0, 0);
    cyc(1, 1, 32'h600, 0, 2'b00, 0, 0);
    chk("stb_legal", 32'(d_stb), 0);
    cyc(0, 0, 32'h0, 0, 2'b00, 1, 0);
    cyc(1, 0, 32'h200, 0, 2'b00, 0, 0);
    chk("stb_wait", 32'(d_stb), 0);
    cyc(1, 1, 32'h204, 0, 2'b00, 0, 0);
    chk("stb_set", 32'(d_stb), 1);
    cyc(0, 0, 32'h0, 0, 2'b00, 1, 0);
    chk("stb_pop", d_addr, 32'h204);
    cyc(0, 0, 32'h0, 0, 2'b00, 1, 0);
    chk("unf_set", 32'(d_unf), 1);
    chk("unf_novld", 32'(d_vld), 0);
    cyc(1, 1, 32'h800, 0, 2'b00, 1, 0);
    chk("unf_pp_out", 32'(d_out), 1);
    chk("unf_pp_novld", 32'(d_vld), 0);
    idle();
    flags("sticky", 1, 1, 1);
    // reset with entries in flight
    cyc(1, 1, 32'h900, 0, 2'b00, 0, 0);
    chk("pre_rst_out", 32'(d_out), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(d_out), 0);
    chk("arst_i_out", 32'(i_out), 0);
    chk("arst_addr", d_addr, 0);
    flags("arst", 0, 0, 0);
    idle();
    rst_n = 1'b1;
    cyc(1, 1, 32'h700, 0, 2'b00, 0, 0);
    cyc(0, 0, 32'h0, 0, 2'b00, 1, 0);
    chk("post_vld", 32'(d_vld), 1);
    chk("post_addr", d_addr, 32'h700);
    chk("post_out", 32'(d_out), 0);
    flags("post", 0, 0, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
